a2d_spi_resp: RTL
=================

// Module: a2d_spi_resp
// PURPOSE
//  SPI slave responder modelling the 8-channel 12-bit A2D at the far end of the A2D SPI link.
//  Receives 16-bit commands {2'b00,chnnl[2:0],11'h000} from SPI_mnrch and captures a sample for the
//  addressed channel. It returns that sample as {4'h0,res[11:0]} on the next transaction.
//  Used as the A2D stand-in in full-chip sims and as a synthesizable loopback target on FPGA.
// PARAMETERS
//  CONV_CLKS  4   clk cycles between command decode and sample capture (models conversion time, >=1)
// PORTS
//  clk       in   1   system clock, 50MHz
//  rst_n     in   1   asynchronous active-low reset
//  SS_n      in   1   active-low slave select from master
//  SCLK      in   1   SPI clock from master (idles high, >= 8 clk per half period)
//  MOSI      in   1   serial command from master, MSB first
//  MISO      out  1   serial response to master, MSB first
//  chnnl     out  3   channel of most recent valid command; selects samp source
//  samp      in   12  sample value of channel chnnl, supplied by bench/pot model
//  cnv_done  out  1   1-clk pulse when samp captured into response register
//  err       out  1   1-clk pulse on bad command or frame length != 16
// BEHAVIOUR
//  Reset values: MISO=0, chnnl=0, cnv_done=0, err=0, response reg=16'h0000, state=RST_WT.
//  Reset also sets the SS_n and SCLK 2-flop synchronizers to 1 and the MOSI synchronizer to 0.
//  Synchronization:
//  - SS_n, SCLK and MOSI pass through 2-flop synchronizers plus an edge-detect flop.
//  - ss_fall, sclk_rise and sclk_fall are 1-clk pulses in the clk domain.
//  Protocol timing:
//  - Master samples MISO and changes MOSI relative to SCLK. Responder samples MOSI on sclk_rise.
//  - Responder shifts tx left on sclk_fall, except the first sclk_fall of a frame; MSB is presented from ss_fall.
//  - MISO = tx[15] when raw SS_n==0, else 1'b0.
//  State machine:
//  - RST_WT: ignore everything until synced SS_n==1 -> IDLE. A frame in flight at reset release is dropped.
//  - IDLE: on ss_fall, load tx <= resp, clear bit_cnt and first flag -> SHIFT.
//  - SHIFT: on sclk_rise, rx <= {rx[14:0],MOSI_sync}, bit_cnt++ (5-bit, saturates at 31).
//    On sclk_fall, if !first then tx <= {tx[14:0],1'b0}, else first=0.
//    On synced SS_n rise:
//      * bit_cnt==16 and rx[15:14]==2'b00 and rx[10:0]==0 -> chnnl <= rx[13:11], clear conv_cnt -> CONV.
//      * otherwise pulse err, leave chnnl and resp unchanged -> IDLE.
//  - CONV: conv_cnt++ each clk. When conv_cnt==CONV_CLKS-1: resp <= {4'h0,samp}, pulse cnv_done -> IDLE.
//    On ss_fall in CONV: abort the conversion (no cnv_done), load tx with the old resp, -> SHIFT.
//    The new chnnl stays in effect.
//  Latency: SS_n rise to cnv_done = 3 (sync/edge) + 1 (decode) + CONV_CLKS clk.
//  Response mapping: the response to frame N is the sample captured for frame N-1's command.
//  The first frame after reset returns 16'h0000.
//  Boundaries:
//  - SCLK edges while SS_n high are ignored.
//  - Simultaneous sclk_rise and SS_n rise cannot occur (master guarantees a gap); if seen, the SS_n rise wins.
//  - rst_n asserted mid-frame: MISO=0 immediately (async), return to RST_WT.
// TESTING
//  1. Reset, samp=12'hABC; frame cmd 16'h1000 (ch2) -> rd_data 16'h0000, chnnl=2, cnv_done ~CONV_CLKS+4 clk after SS_n rise.
//  2. Follow with frame 16'h1000, samp=12'h123 -> rd_data 16'h0ABC; third frame -> 16'h0123.
//  3. Drive A2D_intf strt_cnv with chnnl=5, samp=12'h7F0 -> res=12'h7F0 with cnv_cmplt; A2D_intf WAIT gap < CONV_CLKS not allowed, so bench uses CONV_CLKS=1.
//  4. Bad cmd 16'hC000 -> err pulse, chnnl unchanged, next frame returns previous resp.
//  5. Frame truncated after 9 SCLKs -> err pulse, no CONV; next full frame behaves as if truncated frame never happened.
//  6. Assert rst_n low at bit 7 with SS_n low, release while SS_n low -> MISO=0, no decode; first post-reset frame returns 16'h0000.

Source files
------------

// File: rtl/a2d_spi_resp.sv
// SPI slave standing in for the 8-channel 12-bit A2D: decodes channel commands and
// returns the sample captured for the previous command on the next frame.
module a2d_spi_resp #(
    parameter int CONV_CLKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic [2:0]  chnnl,
    input  logic [11:0] samp,
    output logic        cnv_done,
    output logic        err
);

    typedef enum logic [1:0] {RST_WT, IDLE, SHIFT, CONV} state_t;

    localparam int CW = (CONV_CLKS > 1) ? $clog2(CONV_CLKS) : 1;
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CLKS - 1);

    // [0] first sync flop, [1] synchronized value, [2] previous synchronized value
    logic [2:0]    ss_sh, sclk_sh, mosi_sh;
    logic          ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [1:0]    arm;

    state_t        state, nxt_state;
    logic [15:0]   tx, rx, resp;
    logic [4:0]    bit_cnt;
    logic          first;
    logic [CW-1:0] conv_cnt;

    logic          ld_tx, sh_rx, sh_tx, clr_first, set_chnnl, capture, err_nxt;
    logic          cmd_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sh     <= 3'b111;
            sclk_sh   <= 3'b111;
            mosi_sh   <= 3'b000;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            arm       <= 2'b00;
        end else begin
            ss_sh     <= {ss_sh[1:0], SS_n};
            sclk_sh   <= {sclk_sh[1:0], SCLK};
            mosi_sh   <= {mosi_sh[1:0], MOSI};
            ss_fall   <= ss_sh[2] & ~ss_sh[1];
            ss_rise   <= ~ss_sh[2] & ss_sh[1];
            sclk_rise <= ~sclk_sh[2] & sclk_sh[1];
            sclk_fall <= sclk_sh[2] & ~sclk_sh[1];
            arm       <= {arm[0], 1'b1};
        end
    end

    assign cmd_ok = (bit_cnt == 5'd16) && (rx[15:14] == 2'b00) && (rx[10:0] == 11'h000);

    // NOTE: every output of this block gets a default first so no latches are inferred.
    always_comb begin
        nxt_state = state;
        ld_tx     = 1'b0;
        sh_rx     = 1'b0;
        sh_tx     = 1'b0;
        clr_first = 1'b0;
        set_chnnl = 1'b0;
        capture   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            // Synchronizer flops reset high, so wait until they have really sampled SS_n.
            RST_WT: if (arm[1] && ss_sh[1]) nxt_state = IDLE;
            IDLE: begin
                if (ss_fall) begin
                    ld_tx     = 1'b1;
                    nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    if (cmd_ok) begin
                        set_chnnl = 1'b1;
                        nxt_state = CONV;
                    end else begin
                        err_nxt   = 1'b1;
                        nxt_state = IDLE;
                    end
                end else begin
                    sh_rx = sclk_rise;
                    if (sclk_fall) begin
                        if (first) clr_first = 1'b1;
                        else       sh_tx     = 1'b1;
                    end
                end
            end
            CONV: begin
                if (ss_fall) begin
                    ld_tx     = 1'b1;
                    nxt_state = SHIFT;
                end else if (conv_cnt == CONV_LAST) begin
                    capture   = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = RST_WT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_WT;
            tx       <= 16'h0000;
            rx       <= 16'h0000;
            resp     <= 16'h0000;
            bit_cnt  <= 5'd0;
            first    <= 1'b0;
            conv_cnt <= '0;
            chnnl    <= 3'd0;
            cnv_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnv_done <= capture;
            err      <= err_nxt;
            if (ld_tx) begin
                tx      <= resp;
                bit_cnt <= 5'd0;
                first   <= 1'b1;
            end else if (sh_tx) begin
                tx <= {tx[14:0], 1'b0};
            end
            if (clr_first) first <= 1'b0;
            if (sh_rx) begin
                rx <= {rx[14:0], mosi_sh[2]};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end
            if (set_chnnl) begin
                chnnl    <= rx[13:11];
                conv_cnt <= '0;
            end else if (state == CONV) begin
                conv_cnt <= conv_cnt + CW'(1);
            end
            if (capture) resp <= {4'h0, samp};
        end
    end

    assign MISO = (rst_n && !SS_n) ? tx[15] : 1'b0;

endmodule
